// File: rtl/cordic_rotation_top.sv
// Iterative rotation-mode CORDIC: rotates (x, y) by a binary-angle input, one micro-rotation per
// clock, then compensates the CORDIC gain with a Q8 multiply and saturates to the output width.
module cordic_rotation_top #(
    parameter int unsigned data_width   = 16,
    parameter int unsigned cordic_steps = 16,
    parameter int unsigned angle_width  = 20
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic signed [data_width-1:0]   x_in,
    input  logic signed [data_width-1:0]   y_in,
    input  logic signed [angle_width-1:0]  angle_in,
    output logic signed [data_width-1:0]   x_out,
    output logic signed [data_width-1:0]   y_out,
    output logic [cordic_steps-1:0]        micro_rotation,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned iw = data_width + 2;
    localparam int unsigned pw = iw + 9;
    localparam int unsigned cw = (cordic_steps > 1) ? $clog2(cordic_steps) : 1;
    localparam int          atan_shift = int'(angle_width) - 20;
    localparam logic signed [pw-1:0] k_inv = pw'(155);
    localparam logic signed [pw-1:0] sat_max =
        {{(pw - data_width + 1){1'b0}}, {(data_width - 1){1'b1}}};
    localparam logic signed [pw-1:0] sat_min =
        {{(pw - data_width + 1){1'b1}}, {(data_width - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StIter, StScale} state_t;

    // Table is held at 20-bit binary-angle scale and shifted for other angle widths.
    function automatic logic signed [angle_width-1:0] atan_lut(input int unsigned idx);
        int     base;
        longint v;
        case (idx)
            0:  base = 131072;
            1:  base = 77376;
            2:  base = 40884;
            3:  base = 20753;
            4:  base = 10417;
            5:  base = 5213;
            6:  base = 2607;
            7:  base = 1304;
            8:  base = 652;
            9:  base = 326;
            10: base = 163;
            11: base = 81;
            12: base = 41;
            13: base = 20;
            14: base = 10;
            15: base = 5;
            16: base = 3;
            17: base = 1;
            18: base = 1;
            default: base = 0;
        endcase
        if (atan_shift >= 0) v = longint'(base) <<< atan_shift;
        else                 v = longint'(base) >>> (-atan_shift);
        return v[angle_width-1:0];
    endfunction

    function automatic logic signed [data_width-1:0] sat(input logic signed [pw-1:0] v);
        if (v > sat_max)      return sat_max[data_width-1:0];
        else if (v < sat_min) return sat_min[data_width-1:0];
        else                  return v[data_width-1:0];
    endfunction

    state_t                         state_q;
    logic signed [iw-1:0]           x_q, y_q;
    logic signed [angle_width-1:0]  z_q;
    logic [cw-1:0]                  step_q;
    logic [cordic_steps-1:0]        rot_q;

    logic                           d_pos, fold, last_step;
    logic signed [iw-1:0]           x_ext, y_ext, x_sh, y_sh, x_step, y_step;
    logic signed [angle_width-1:0]  atan_cur, z_step, z_init;
    logic signed [pw-1:0]           x_scaled, y_scaled;

    always_comb begin
        d_pos     = ~z_q[angle_width-1];
        atan_cur  = atan_lut(32'(step_q));
        x_sh      = x_q >>> step_q;
        y_sh      = y_q >>> step_q;
        x_step    = d_pos ? x_q - y_sh : x_q + y_sh;
        y_step    = d_pos ? y_q + x_sh : y_q - x_sh;
        z_step    = d_pos ? z_q - atan_cur : z_q + atan_cur;
        last_step = (step_q == cw'(cordic_steps - 1));
        // |angle| >= 90 deg: rotate by angle-180 and pre-negate the vector instead.
        fold      = angle_in[angle_width-1] ^ angle_in[angle_width-2];
        x_ext     = iw'(x_in);
        y_ext     = iw'(y_in);
        z_init    = fold ? {~angle_in[angle_width-1], angle_in[angle_width-2:0]} : angle_in;
        x_scaled  = (pw'(x_q) * k_inv) >>> 8;
        y_scaled  = (pw'(y_q) * k_inv) >>> 8;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            x_q            <= '0;
            y_q            <= '0;
            z_q            <= '0;
            step_q         <= '0;
            rot_q          <= '0;
            x_out          <= '0;
            y_out          <= '0;
            micro_rotation <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        x_q     <= fold ? -x_ext : x_ext;
                        y_q     <= fold ? -y_ext : y_ext;
                        z_q     <= z_init;
                        step_q  <= '0;
                        rot_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StIter;
                    end
                end
                StIter: begin
                    x_q           <= x_step;
                    y_q           <= y_step;
                    z_q           <= z_step;
                    rot_q[step_q] <= d_pos;
                    step_q        <= step_q + 1'b1;
                    if (last_step) state_q <= StScale;
                end
                StScale: begin
                    x_out          <= sat(x_scaled);
                    y_out          <= sat(y_scaled);
                    micro_rotation <= rot_q;
                    done           <= 1'b1;
                    busy           <= 1'b0;
                    state_q        <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
